seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param_pkg.sv | 16 +
 rtl/seq_detector_param_sat_counter.sv | 34 +++
 rtl/seq_detector_param.sv | 103 ++++++++++
 tb/tb_seq_detector_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the programmable sequence detector: reset configuration
// defaults and the pattern-length field width helper.
package seq_det_pkg;

    localparam int unsigned DEF_MAX_LEN     = 8;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam logic [7:0]  DEF_RST_PATTERN = 8'b0000_0110;
    localparam int unsigned DEF_RST_LEN     = 4;
    localparam logic        DEF_RST_OVERLAP = 1'b1;

    // Bits needed to hold a length in 0..max_len
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear-then-count when both are asserted.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with stall qualifier, overlap
// mode and a saturating match counter. Reset config behaves as the "0110" detector.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned          CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int unsigned          RST_LEN     = DEF_RST_LEN,
    parameter logic                 RST_OVERLAP = DEF_RST_OVERLAP,
    localparam int unsigned         LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_i,
    input  logic               in_valid_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               clr_count_i,
    output logic               out_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               cfg_err_o
);

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic               err_q,  err_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q,  out_d;

    logic [MAX_LEN-1:0] hist_shift_c;
    logic [LEN_W-1:0]   fill_inc_c;
    logic [MAX_LEN-1:0] mask_c;
    logic               match_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= RST_OVERLAP;
            err_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            err_q  <= err_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    // Post-shift history/fill; a shift past MAX_LEN yields an all-ones mask
    assign hist_shift_c = MAX_LEN'({hist_q, in_i});
    assign fill_inc_c   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign mask_c       = ~({MAX_LEN{1'b1}} << len_q);

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        out_d   = 1'b0;
        match_c = 1'b0;
        if (cfg_load_i) begin
            pat_d  = cfg_pattern_i;
            len_d  = cfg_len_i;
            ovl_d  = cfg_overlap_i;
            err_d  = (cfg_len_i == '0) || (cfg_len_i > LEN_W'(MAX_LEN));
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid_i) begin
            match_c = !err_q && (fill_inc_c >= len_q)
                      && ((hist_shift_c & mask_c) == (pat_q & mask_c));
            hist_d  = hist_shift_c;
            fill_d  = (match_c && !ovl_q) ? '0 : fill_inc_c;
            out_d   = match_c;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (match_c),
        .clr_i   (clr_count_i),
        .count_o (match_count_o)
    );

    assign out_o     = out_q;
    assign cfg_err_o = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus a randomized run against
// a queue-based model of "last len fresh bits equal the pattern".
module tb_seq_detector_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_b = 1'b0;
    logic             in_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [7:0]       cfg_pattern = 8'h00;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             clr_count = 1'b0;

    logic             out_a, err_a, out_s, err_s;
    logic [7:0]       cnt_a;
    logic [1:0]       cnt_s;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    bit         mq[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl, m_err, exp_out;
    int         exp_cnt8, exp_cnt2;

    seq_detector_param dut (
        .clk(clk), .rstn(rstn), .in_i(in_b), .in_valid_i(in_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap), .clr_count_i(clr_count),
        .out_o(out_a), .match_count_o(cnt_a), .cfg_err_o(err_a)
    );

    seq_detector_param #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .in_i(in_b), .in_valid_i(in_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap), .clr_count_i(clr_count),
        .out_o(out_s), .match_count_o(cnt_s), .cfg_err_o(err_s)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_pat = 8'b0000_0110; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
        exp_out = 1'b0; exp_cnt8 = 0; exp_cnt2 = 0;
    endtask

    // One clock edge of the model, using the inputs currently driven
    task automatic model_edge();
        bit hit = 1'b0;
        if (cfg_load) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            m_err = (m_len == 0) || (m_len > int'(MAX_LEN));
            mq.delete();
        end else if (in_valid) begin
            mq.push_back(in_b);
            if (mq.size() > int'(MAX_LEN)) void'(mq.pop_front());
            if (!m_err && mq.size() >= m_len) begin
                hit = 1'b1;
                for (int j = 0; j < m_len; j++)
                    if (mq[mq.size() - 1 - j] != m_pat[j]) hit = 1'b0;
            end
            if (hit && !m_ovl) mq.delete();
        end
        exp_out = hit;
        if (clr_count) begin
            exp_cnt8 = int'(hit); exp_cnt2 = int'(hit);
        end else if (hit) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
    endtask

    task automatic step(input bit b, input bit v, input bit ld, input bit clr);
        in_b = b; in_valid = v; cfg_load = ld; clr_count = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l, input bit o);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step(1'($urandom), 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", out_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_a); end
        n_cmp++; if (cnt_s !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_sat: got %0d expected 0", cnt_s); end
        rstn = 1'b1;
    endtask

    task automatic test_legacy();
        bit bits [7] = '{0, 1, 1, 0, 1, 1, 0};
        bit pul  [7] = '{0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (out_a !== pul[i]) begin n_fail++; $display("FAIL legacy_out[%0d]: got %b expected %b", i, out_a, pul[i]); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL legacy_tail_out: got %b expected 0", out_a); end
        n_cmp++; if (cnt_a !== 8'd2) begin n_fail++; $display("FAIL legacy_cnt: got %0d expected 2", cnt_a); end
    endtask

    task automatic test_nonoverlap();
        bit bits [7] = '{0, 1, 1, 0, 1, 1, 0};
        bit pul  [7] = '{0, 0, 0, 1, 0, 0, 0};
        load(8'b0110, 4'd4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (out_a !== pul[i]) begin n_fail++; $display("FAIL nonovl_out[%0d]: got %b expected %b", i, out_a, pul[i]); end
        end
        n_cmp++; if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL nonovl_cnt: got %0d expected 1", cnt_a); end
    endtask

    task automatic test_stall();
        bit bits [5] = '{1, 0, 1, 0, 1};
        bit pul  [5] = '{0, 0, 1, 0, 1};
        load(8'b101, 4'd3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (out_a !== pul[i]) begin n_fail++; $display("FAIL stall_out[%0d]: got %b expected %b", i, out_a, pul[i]); end
            for (int k = 0; k < 2; k++) begin
                step(1'($urandom), 1'b0, 1'b0, 1'b0);
                n_cmp++;
                if (out_a !== 1'b0) begin n_fail++; $display("FAIL stall_gap_out[%0d.%0d]: got %b expected 0", i, k, out_a); end
            end
        end
        n_cmp++; if (cnt_a !== 8'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 2", cnt_a); end
    endtask

    task automatic test_cfg_err();
        bit bits [4] = '{0, 1, 1, 0};
        logic [LEN_W-1:0] lens [3] = '{4'd0, 4'd9, 4'd4};
        for (int c = 0; c < 3; c++) begin
            load(8'b0110, lens[c], 1'b1);
            n_cmp++;
            if (err_a !== (c < 2)) begin n_fail++; $display("FAIL cfgerr_flag[len=%0d]: got %b expected %b", lens[c], err_a, c < 2); end
            for (int i = 0; i < 4; i++) begin
                step(bits[i], 1'b1, 1'b0, 1'b0);
                n_cmp++;
                if (out_a !== (c == 2 && i == 3)) begin
                    n_fail++; $display("FAIL cfgerr_out[len=%0d,%0d]: got %b expected %b", lens[c], i, out_a, c == 2 && i == 3);
                end
            end
            n_cmp++;
            if (cnt_a !== ((c == 2) ? 8'd3 : 8'd2)) begin
                n_fail++; $display("FAIL cfgerr_cnt[len=%0d]: got %0d expected %0d", lens[c], cnt_a, (c == 2) ? 3 : 2);
            end
        end
    endtask

    task automatic test_saturate();
        bit [1:0] exp_s [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        load(8'b1, 4'd1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (cnt_s !== exp_s[i]) begin n_fail++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", i, cnt_s, exp_s[i]); end
            n_cmp++;
            if (cnt_a !== 8'(i + 1)) begin n_fail++; $display("FAIL sat_cnt8[%0d]: got %0d expected %0d", i, cnt_a, i + 1); end
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (cnt_s !== 2'd1) begin n_fail++; $display("FAIL clr_match_cnt2: got %0d expected 1", cnt_s); end
        n_cmp++; if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL clr_match_cnt8: got %0d expected 1", cnt_a); end
        n_cmp++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL clr_match_out: got %b expected 1", out_a); end
    endtask

    task automatic test_reset_mid();
        bit bits [4] = '{0, 1, 1, 0};
        load(8'b0110, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) step(bits[i], 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", cnt_a); end
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got %b expected 0", out_a); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_out: got %b expected 0", out_a); end
        for (int i = 0; i < 4; i++) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (out_a !== (i == 3)) begin n_fail++; $display("FAIL midrst_full_out[%0d]: got %b expected %b", i, out_a, i == 3); end
        end
        // The load-cycle 0 must be dropped, so 1,1,0 alone cannot complete 0110
        cfg_pattern = 8'b0110; cfg_len = 4'd4; cfg_overlap = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (out_a !== 1'b0) begin n_fail++; $display("FAIL load_drop_out[%0d]: got %b expected 0", i, out_a); end
        end
    endtask

    task automatic test_random();
        int hits = 0;
        for (int n = 0; n < 3000; n++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 3) begin
                cfg_pattern = 8'($urandom);
                cfg_len = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 5));
                cfg_overlap = 1'($urandom);
                step(1'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 49) == 0);
            end else begin
                step(1'($urandom), $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 49) == 0);
            end
            if (exp_out) hits++;
            n_cmp++; if (out_a !== exp_out) begin n_fail++; $display("FAIL rnd_out[%0d]: got %b expected %b", n, out_a, exp_out); end
            n_cmp++; if (cnt_a !== 8'(exp_cnt8)) begin n_fail++; $display("FAIL rnd_cnt8[%0d]: got %0d expected %0d", n, cnt_a, exp_cnt8); end
            n_cmp++; if (cnt_s !== 2'(exp_cnt2)) begin n_fail++; $display("FAIL rnd_cnt2[%0d]: got %0d expected %0d", n, cnt_s, exp_cnt2); end
            n_cmp++; if (err_a !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, err_a, m_err); end
            n_cmp++; if (out_s !== exp_out || err_s !== m_err) begin
                n_fail++; $display("FAIL rnd_sat_inst[%0d]: got out=%b err=%b expected out=%b err=%b", n, out_s, err_s, exp_out, m_err);
            end
        end
        n_cmp++; if (hits == 0) begin n_fail++; $display("FAIL rnd_activity: got %0d matches expected >0", hits); end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_nonoverlap();
        test_stall();
        test_cfg_err();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
